// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control: accepts address phases, inserts data-phase wait
// states, issues the two-cycle ERROR response and strobes the register file.
module ahb_slave_ctrl #(
   parameter int WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic        hready,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  haddr,
   input  logic [31:0] hwdata,
   input  logic        dec_err,
   input  logic [1:0]  dec_wsel,
   input  logic [1:0]  dec_rsel,
   input  logic [31:0] reg_rdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic        reg_wen,
   output logic [1:0]  reg_wsel,
   output logic [31:0] reg_wdata,
   output logic [1:0]  reg_rsel,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_DONE = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_t;

   localparam bit         HAS_WAIT  = (WAIT_STATES > 0) ? 1'b1 : 1'b0;
   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t      state_r;
   logic [2:0]  wait_cnt_r;
   logic        write_r;
   logic        rd_done_r;
   logic        accept_s;
   logic        unused_s;

   // Address phase qualifier: only NONSEQ/SEQ with the bus ready count.
   assign accept_s = hsel & hready & htrans[1];

   // Address decoding happens upstream; these inputs are intentionally not consumed.
   assign unused_s = ^{haddr, htrans[0]};

   // Transfer FSM with registered bus and register-file handshake outputs.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 3'd0;
         write_r    <= 1'b0;
         rd_done_r  <= 1'b0;
         hreadyout  <= 1'b1;
         hresp      <= 1'b0;
         reg_wen    <= 1'b0;
         reg_wsel   <= 2'd0;
         reg_rsel   <= 2'd0;
         err_count  <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR2: begin
               if (accept_s) begin
                  write_r  <= hwrite;
                  reg_wsel <= dec_wsel;
                  reg_rsel <= dec_rsel;
                  if (dec_err) begin
                     state_r   <= ST_ERR1;
                     hreadyout <= 1'b0;
                     hresp     <= 1'b1;
                     reg_wen   <= 1'b0;
                     rd_done_r <= 1'b0;
                     if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                     end else begin
                        err_count <= err_count;
                     end
                  end else if (HAS_WAIT) begin
                     state_r    <= ST_WAIT;
                     wait_cnt_r <= WAIT_LOAD;
                     hreadyout  <= 1'b0;
                     hresp      <= 1'b0;
                     reg_wen    <= 1'b0;
                     rd_done_r  <= 1'b0;
                  end else begin
                     state_r   <= ST_DONE;
                     hreadyout <= 1'b1;
                     hresp     <= 1'b0;
                     reg_wen   <= hwrite;
                     rd_done_r <= ~hwrite;
                  end
               end else begin
                  state_r   <= ST_IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= 1'b0;
                  reg_wen   <= 1'b0;
                  rd_done_r <= 1'b0;
               end
            end
            ST_WAIT: begin
               hresp <= 1'b0;
               if (wait_cnt_r == 3'd0) begin
                  state_r   <= ST_DONE;
                  hreadyout <= 1'b1;
                  reg_wen   <= write_r;
                  rd_done_r <= ~write_r;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 3'd1;
                  hreadyout  <= 1'b0;
                  reg_wen    <= 1'b0;
                  rd_done_r  <= 1'b0;
               end
            end
            ST_ERR1: begin
               state_r   <= ST_ERR2;
               hreadyout <= 1'b1;
               hresp     <= 1'b1;
               reg_wen   <= 1'b0;
               rd_done_r <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               hreadyout <= 1'b1;
               hresp     <= 1'b0;
               reg_wen   <= 1'b0;
               rd_done_r <= 1'b0;
            end
         endcase
      end
   end

   // Data-phase buses follow the live hwdata/reg_rdata, gated by the registered strobes.
   always_comb begin
      if (rd_done_r) begin
         hrdata = reg_rdata;
      end else begin
         hrdata = 32'd0;
      end
      if (reg_wen) begin
         reg_wdata = hwdata;
      end else begin
         reg_wdata = 32'd0;
      end
   end

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Directed bench for ahb_slave_ctrl at WAIT_STATES = 0, 2 and 3.
module tb_ahb_slave_ctrl;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic        hready;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  haddr;
   logic [31:0] hwdata;
   logic        dec_err;
   logic [1:0]  dec_wsel;
   logic [1:0]  dec_rsel;
   logic [31:0] reg_rdata;

   logic        o0_hreadyout, o2_hreadyout, o3_hreadyout;
   logic        o0_hresp, o2_hresp, o3_hresp;
   logic [31:0] o0_hrdata, o2_hrdata, o3_hrdata;
   logic        o0_reg_wen, o2_reg_wen, o3_reg_wen;
   logic [1:0]  o0_reg_wsel, o2_reg_wsel, o3_reg_wsel;
   logic [31:0] o0_reg_wdata, o2_reg_wdata, o3_reg_wdata;
   logic [1:0]  o0_reg_rsel, o2_reg_rsel, o3_reg_rsel;
   logic [7:0]  o0_err_count, o2_err_count, o3_err_count;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   ahb_slave_ctrl #(.WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .htrans(htrans),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .dec_err(dec_err),
      .dec_wsel(dec_wsel), .dec_rsel(dec_rsel), .reg_rdata(reg_rdata),
      .hreadyout(o0_hreadyout), .hresp(o0_hresp), .hrdata(o0_hrdata),
      .reg_wen(o0_reg_wen), .reg_wsel(o0_reg_wsel), .reg_wdata(o0_reg_wdata),
      .reg_rsel(o0_reg_rsel), .err_count(o0_err_count)
   );

   ahb_slave_ctrl #(.WAIT_STATES(2)) u_dut2 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .htrans(htrans),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .dec_err(dec_err),
      .dec_wsel(dec_wsel), .dec_rsel(dec_rsel), .reg_rdata(reg_rdata),
      .hreadyout(o2_hreadyout), .hresp(o2_hresp), .hrdata(o2_hrdata),
      .reg_wen(o2_reg_wen), .reg_wsel(o2_reg_wsel), .reg_wdata(o2_reg_wdata),
      .reg_rsel(o2_reg_rsel), .err_count(o2_err_count)
   );

   ahb_slave_ctrl #(.WAIT_STATES(3)) u_dut3 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .htrans(htrans),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .dec_err(dec_err),
      .dec_wsel(dec_wsel), .dec_rsel(dec_rsel), .reg_rdata(reg_rdata),
      .hreadyout(o3_hreadyout), .hresp(o3_hresp), .hrdata(o3_hrdata),
      .reg_wen(o3_reg_wen), .reg_wsel(o3_reg_wsel), .reg_wdata(o3_reg_wdata),
      .reg_rsel(o3_reg_rsel), .err_count(o3_err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_bus;
      hsel    = 1'b0;
      hready  = 1'b1;
      htrans  = 2'd0;
      hwrite  = 1'b0;
      dec_err = 1'b0;
   endtask

   task automatic do_reset;
      idle_bus();
      hreset = 1'b1;
      cyc();
      cyc();
      hreset = 1'b0;
   endtask

   // Accepts one errored write, returns positioned in the ERR2 cycle with no new request.
   task automatic err_xfer;
      hsel    = 1'b1;
      hready  = 1'b1;
      htrans  = 2'd2;
      hwrite  = 1'b1;
      dec_err = 1'b1;
      cyc();
      hready  = 1'b0;
      htrans  = 2'd0;
      dec_err = 1'b0;
      cyc();
      hready  = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      hreset    = 1'b1;
      idle_bus();
      haddr     = 3'd0;
      hwdata    = 32'd0;
      dec_wsel  = 2'd0;
      dec_rsel  = 2'd0;
      reg_rdata = 32'd0;

      // Reset values
      cyc();
      chk("rst_hreadyout", {31'd0, o0_hreadyout}, 32'd1);
      chk("rst_hresp",     {31'd0, o0_hresp},     32'd0);
      chk("rst_hrdata",    o0_hrdata,             32'd0);
      chk("rst_reg_wen",   {31'd0, o0_reg_wen},   32'd0);
      chk("rst_reg_wdata", o0_reg_wdata,          32'd0);
      chk("rst_err_count", {24'd0, o0_err_count}, 32'd0);
      chk("rst_ready_ws2", {31'd0, o2_hreadyout}, 32'd1);

      // Zero-wait write accepted on the first edge after reset release
      do_reset();
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      haddr = 3'd2; dec_wsel = 2'd0; dec_rsel = 2'd1; hwdata = 32'hA5A5_0001;
      cyc();
      idle_bus();
      #1;
      chk("wr_ready",  {31'd0, o0_hreadyout}, 32'd1);
      chk("wr_hresp",  {31'd0, o0_hresp},     32'd0);
      chk("wr_wen",    {31'd0, o0_reg_wen},   32'd1);
      chk("wr_wsel",   {30'd0, o0_reg_wsel},  32'd0);
      chk("wr_wdata",  o0_reg_wdata,          32'hA5A5_0001);
      chk("wr_hrdata", o0_hrdata,             32'd0);
      cyc();
      chk("wr_wen_off",   {31'd0, o0_reg_wen}, 32'd0);
      chk("wr_wdata_off", o0_reg_wdata,        32'd0);

      // Non-accepted cycles: BUSY, unselected, bus not ready
      hsel = 1'b1; htrans = 2'd1; hwrite = 1'b1;
      cyc();
      chk("busy_wen",   {31'd0, o0_reg_wen},   32'd0);
      chk("busy_ready", {31'd0, o0_hreadyout}, 32'd1);
      hsel = 1'b0; htrans = 2'd2;
      cyc();
      chk("nosel_wen", {31'd0, o0_reg_wen}, 32'd0);
      hsel = 1'b1; hready = 1'b0;
      cyc();
      chk("nordy_wen", {31'd0, o0_reg_wen}, 32'd0);
      idle_bus();

      // Two wait states on a read
      do_reset();
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b0;
      dec_rsel = 2'd3; reg_rdata = 32'h0000_0010;
      cyc();
      idle_bus(); hready = 1'b0;
      #1;
      chk("ws2_ready0", {31'd0, o2_hreadyout}, 32'd0);
      chk("ws2_rdata0", o2_hrdata,             32'd0);
      chk("ws2_rsel",   {30'd0, o2_reg_rsel},  32'd3);
      cyc();
      chk("ws2_ready1", {31'd0, o2_hreadyout}, 32'd0);
      chk("ws2_rdata1", o2_hrdata,             32'd0);
      hready = 1'b1;
      cyc();
      chk("ws2_ready2", {31'd0, o2_hreadyout}, 32'd1);
      chk("ws2_rdata2", o2_hrdata,             32'h0000_0010);
      chk("ws2_hresp",  {31'd0, o2_hresp},     32'd0);
      cyc();
      chk("ws2_rdata3", o2_hrdata, 32'd0);

      // Decode error on a write
      do_reset();
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      dec_err = 1'b1; dec_wsel = 2'd3; hwdata = 32'hDEAD_BEEF;
      cyc();
      hready = 1'b0; htrans = 2'd0; dec_err = 1'b0;
      #1;
      chk("err1_ready", {31'd0, o0_hreadyout}, 32'd0);
      chk("err1_hresp", {31'd0, o0_hresp},     32'd1);
      chk("err1_wen",   {31'd0, o0_reg_wen},   32'd0);
      chk("err1_count", {24'd0, o0_err_count}, 32'd1);
      cyc();
      hready = 1'b1;
      chk("err2_ready", {31'd0, o0_hreadyout}, 32'd1);
      chk("err2_hresp", {31'd0, o0_hresp},     32'd1);
      chk("err2_wen",   {31'd0, o0_reg_wen},   32'd0);
      cyc();
      chk("errend_hresp", {31'd0, o0_hresp},   32'd0);
      chk("errend_wen",   {31'd0, o0_reg_wen}, 32'd0);
      idle_bus();

      // Back-to-back NONSEQ write then SEQ read
      do_reset();
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      haddr = 3'd1; dec_wsel = 2'd1;
      cyc();
      htrans = 2'd3; hwrite = 1'b0; dec_rsel = 2'd2;
      hwdata = 32'h1234_5678; reg_rdata = 32'hCAFE_0002;
      #1;
      chk("b2b_wen1",   {31'd0, o0_reg_wen},   32'd1);
      chk("b2b_wsel",   {30'd0, o0_reg_wsel},  32'd1);
      chk("b2b_wdata",  o0_reg_wdata,          32'h1234_5678);
      chk("b2b_rdata1", o0_hrdata,             32'd0);
      chk("b2b_ready1", {31'd0, o0_hreadyout}, 32'd1);
      cyc();
      idle_bus();
      #1;
      chk("b2b_wen2",   {31'd0, o0_reg_wen},   32'd0);
      chk("b2b_rdata2", o0_hrdata,             32'hCAFE_0002);
      chk("b2b_rsel",   {30'd0, o0_reg_rsel},  32'd2);
      chk("b2b_ready2", {31'd0, o0_hreadyout}, 32'd1);
      chk("b2b_hresp2", {31'd0, o0_hresp},     32'd0);
      cyc();
      chk("b2b_rdata3", o0_hrdata, 32'd0);

      // Error pipelined in ERR2, then an OKAY read, then saturation
      do_reset();
      err_xfer();
      #1;
      chk("pipe_err2_ready", {31'd0, o0_hreadyout}, 32'd1);
      chk("pipe_err2_hresp", {31'd0, o0_hresp},     32'd1);
      chk("pipe_count1",     {24'd0, o0_err_count}, 32'd1);
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b0; dec_err = 1'b1;
      cyc();
      hready = 1'b0; htrans = 2'd0; dec_err = 1'b0;
      #1;
      chk("pipe_err1_ready", {31'd0, o0_hreadyout}, 32'd0);
      chk("pipe_err1_hresp", {31'd0, o0_hresp},     32'd1);
      chk("pipe_count2",     {24'd0, o0_err_count}, 32'd2);
      cyc();
      hready = 1'b1; htrans = 2'd3; hwrite = 1'b0; dec_rsel = 2'd1;
      reg_rdata = 32'h5A5A_0003;
      #1;
      chk("pipe_err2b_hresp", {31'd0, o0_hresp}, 32'd1);
      cyc();
      idle_bus();
      #1;
      chk("pipe_done_ready", {31'd0, o0_hreadyout}, 32'd1);
      chk("pipe_done_hresp", {31'd0, o0_hresp},     32'd0);
      chk("pipe_done_rdata", o0_hrdata,             32'h5A5A_0003);
      chk("pipe_done_count", {24'd0, o0_err_count}, 32'd2);
      cyc();
      for (int i = 0; i < 253; i++) begin
         err_xfer();
      end
      #1;
      chk("sat_255", {24'd0, o0_err_count}, 32'd255);
      err_xfer();
      #1;
      chk("sat_256",   {24'd0, o0_err_count}, 32'd255);
      chk("sat_hresp", {31'd0, o0_hresp},     32'd1);
      idle_bus();
      cyc();

      // Reset pulse during WAIT aborts the pending write
      do_reset();
      hsel = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = 1'b1;
      dec_wsel = 2'd2; dec_rsel = 2'd3; hwdata = 32'h0BAD_0BAD;
      cyc();
      idle_bus(); hready = 1'b0;
      #1;
      chk("ws3_ready0", {31'd0, o3_hreadyout}, 32'd0);
      chk("ws3_wsel",   {30'd0, o3_reg_wsel},  32'd2);
      cyc();
      chk("ws3_ready1", {31'd0, o3_hreadyout}, 32'd0);
      hreset = 1'b1;
      #1;
      chk("abort_ready",  {31'd0, o3_hreadyout}, 32'd1);
      chk("abort_hresp",  {31'd0, o3_hresp},     32'd0);
      chk("abort_wen",    {31'd0, o3_reg_wen},   32'd0);
      chk("abort_wsel",   {30'd0, o3_reg_wsel},  32'd0);
      chk("abort_rsel",   {30'd0, o3_reg_rsel},  32'd0);
      chk("abort_hrdata", o3_hrdata,             32'd0);
      chk("abort_wdata",  o3_reg_wdata,          32'd0);
      cyc();
      hreset = 1'b0;
      hready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("post_abort_wen",   {31'd0, o3_reg_wen},   32'd0);
         chk("post_abort_ready", {31'd0, o3_hreadyout}, 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_slave_ctrl.md
AHB_SLAVE_CTRL -- requirements
Module: ahb_slave_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 0, data-phase wait cycles inserted before completion of every OKAY transfer; legal range 0..7.
REQ-002 hclk  in  1  sole clock; all state updates on rising edge.
REQ-003 hreset  in  1  reset, asynchronous, active-high.
REQ-004 hsel  in  1  slave select from bus decoder.
REQ-005 hready  in  1  bus-wide ready; an address phase is sampled only when high.
REQ-006 htrans  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-007 hwrite  in  1  1 write, 0 read.
REQ-008 haddr  in  3  register address.
REQ-009 hwdata  in  32  write data, valid in the data phase.
REQ-010 dec_err  in  1  combinational decode error for the current address phase.
REQ-011 dec_wsel  in  2  decoded write-register select.
REQ-012 dec_rsel  in  2  decoded read-register select.
REQ-013 reg_rdata  in  32  read data from register file, selected by reg_rsel.
REQ-014 hreadyout  out  1  slave ready.
REQ-015 hresp  out  1  0 OKAY, 1 ERROR.
REQ-016 hrdata  out  32  read data.
REQ-017 reg_wen  out  1  one-cycle register write strobe.
REQ-018 reg_wsel  out  2  registered write select.
REQ-019 reg_wdata  out  32  write data to register file.
REQ-020 reg_rsel  out  2  registered read select.
REQ-021 err_count  out  8  saturating count of ERROR responses issued.

Function
REQ-022 Address phase accepted when hsel=1, hready=1 and htrans[1]=1; hwrite, dec_err, dec_wsel and dec_rsel are registered at that edge.
REQ-023 hsel=1 with htrans IDLE or BUSY, or hsel=0, causes no access, no state change, and a zero-wait OKAY (hreadyout=1, hresp=0).
REQ-024 FSM states: IDLE, WAIT, DONE, ERR1, ERR2.
REQ-025 IDLE/DONE/ERR2 on accepted transfer with dec_err=1 -> ERR1; with dec_err=0 -> WAIT if WAIT_STATES>0, else DONE; no accepted transfer -> IDLE.
REQ-026 WAIT: hreadyout=0, hresp=0; 3-bit counter loaded with WAIT_STATES-1 on entry and decremented each cycle; -> DONE in the cycle after the count reaches 0, giving exactly WAIT_STATES low-ready cycles.
REQ-027 DONE: hreadyout=1, hresp=0; write: reg_wen=1 for this cycle only, reg_wdata=hwdata, reg_wsel=registered select; read: hrdata=reg_rdata, with reg_rsel driven from the registered select throughout WAIT and DONE.
REQ-028 ERR1: hreadyout=0, hresp=1 -> ERR2 unconditionally; ERR2: hreadyout=1, hresp=1 (two-cycle AHB error response); no register write in either state.
REQ-029 hrdata = 0 in every state other than a read DONE cycle.
REQ-030 Pipelining: a new address phase accepted in DONE or ERR2 takes effect the next cycle with no bubble; hready is low in WAIT and ERR1, so no address is accepted there.
REQ-031 err_count increments by 1 on entry to ERR1 and holds at 255.
REQ-032 reg_wen never asserts for a transfer whose registered dec_err=1.

Reset
REQ-033 While hreset=1: state IDLE, hreadyout=1, hresp=0, hrdata=0, reg_wen=0, reg_wsel=0, reg_rsel=0, reg_wdata=0, wait counter=0, err_count=0.
REQ-034 Reset asserted mid-transfer (WAIT, DONE, ERR1, ERR2) aborts it immediately; no pending write is performed after release.
REQ-035 First accepted address phase is the first rising edge with hreset=0.

Verification
REQ-036 WAIT_STATES=0, NONSEQ write haddr=2, dec_wsel=0, hwdata=0xA5A5_0001 -> next cycle DONE, hreadyout=1, reg_wen=1, reg_wsel=0, reg_wdata=0xA5A5_0001.
REQ-037 WAIT_STATES=2, read dec_rsel=3, reg_rdata=0x0000_0010 -> hreadyout 0,0,1 over three data cycles; hrdata=0x10 only in the third.
REQ-038 dec_err=1 write -> hreadyout/hresp = 0/1 then 1/1; reg_wen stays 0; err_count 0->1.
REQ-039 Back-to-back NONSEQ write then SEQ read at WAIT_STATES=0 -> DONE twice consecutively, reg_wen only in the first.
REQ-040 Error accepted in ERR2 cycle followed by OKAY -> ERR1, ERR2, DONE; 256 errors -> err_count=255.
REQ-041 hreset pulsed during WAIT (WAIT_STATES=3) -> outputs at reset values; no reg_wen after release.
